// File: rtl/minisoc_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encodings,
// requester indices and the default watchdog limit.
package minisoc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } arb_state_e;

    localparam logic REQ_M0 = 1'b0;
    localparam logic REQ_M1 = 1'b1;

    localparam int DEF_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone requester wins; on a tie the
// requester that was not granted last time wins.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       gnt_o,
    output logic       any_o
);

    always_comb begin
        gnt_o = 1'b0;
        case (req_i)
            2'b01:   gnt_o = 1'b0;
            2'b10:   gnt_o = 1'b1;
            2'b11:   gnt_o = ~last_i;
            default: gnt_o = 1'b0;
        endcase
    end

    assign any_o = |req_i;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter, one outstanding transaction at a time.
// Define DMEM_ARB_TIMEOUT_EN to add a slave-response watchdog.
module dmem_arbiter
    import minisoc_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m0_valid,
    input  logic                m0_we,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    output logic                m0_ready,
    output logic [DATA_W-1:0]   m0_rdata,
    output logic                m0_err,
    input  logic                m1_valid,
    input  logic                m1_we,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    output logic                m1_ready,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                m1_err,
    output logic                s_valid,
    output logic                s_we,
    output logic [ADDR_W-1:0]   s_addr,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    input  logic                s_ready,
    input  logic [DATA_W-1:0]   s_rdata,
    output logic                grant,
    output logic                busy
);

    localparam int STRB_W = DATA_W / 8;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("dmem_arbiter: TIMEOUT_CYCLES must be 1..65535");
    end

    arb_state_e          state_q, state_d;
    logic                ptr_q, ptr_d;
    logic                grant_q, grant_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;

    logic                win, any_req;
    logic                timeout, complete, drive;
    logic [DATA_W-1:0]   rdata_c;

    rr_arb2 u_rr (
        .req_i  ({m1_valid, m0_valid}),
        .last_i (ptr_q),
        .gnt_o  (win),
        .any_o  (any_req)
    );

`ifdef DMEM_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] cnt_q, cnt_d;

    // s_ready on the limit cycle wins over the watchdog
    assign timeout = (state_q == ST_BUSY) && !s_ready && (cnt_q == TO_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_IDLE)
            cnt_d = '0;
        else if (state_q == ST_BUSY && !s_ready)
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`else
    assign timeout = 1'b0;
`endif

    assign complete = (state_q == ST_BUSY) && (s_ready || timeout);
    assign drive    = (state_q == ST_BUSY) && !timeout;

    assign s_valid = drive;
    assign s_we    = drive ? we_q    : 1'b0;
    assign s_addr  = drive ? addr_q  : '0;
    assign s_wdata = drive ? wdata_q : '0;
    assign s_wstrb = drive ? wstrb_q : '0;

    assign rdata_c  = (s_ready && !we_q) ? s_rdata : '0;
    assign m0_ready = complete && (grant_q == REQ_M0);
    assign m1_ready = complete && (grant_q == REQ_M1);
    assign m0_rdata = m0_ready ? rdata_c : '0;
    assign m1_rdata = m1_ready ? rdata_c : '0;
    assign m0_err   = m0_ready && timeout;
    assign m1_err   = m1_ready && timeout;

    assign grant = grant_q;
    assign busy  = (state_q != ST_IDLE);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        case (state_q)
            ST_IDLE: if (any_req) begin
                state_d = ST_BUSY;
                grant_d = win;
                ptr_d   = win;
                we_d    = win ? m1_we    : m0_we;
                addr_d  = win ? m1_addr  : m0_addr;
                wdata_d = win ? m1_wdata : m0_wdata;
                wstrb_d = win ? m1_wstrb : m0_wstrb;
            end
            ST_BUSY: if (complete) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // pointer resets to "m1 last" so the first tie goes to m0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= REQ_M1;
            grant_q <= REQ_M0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter; inputs change and outputs are checked
// in the low phase of the clock.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_valid, m0_we, m1_valid, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_ready, m0_err, m1_ready, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid, s_we, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_wstrb;
    logic        grant, busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .m0_valid(m0_valid), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_valid(m1_valid), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .s_valid(s_valid), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(grant), .busy(busy)
    );

    task automatic idle_inputs();
        m0_valid = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
        m1_valid = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
        s_ready = 0; s_rdata = 0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %h exp 0", busy); end
        checks++; if (grant !== 1'b0) begin errors++; $display("FAIL rst_grant got %h exp 0", grant); end
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL rst_svalid got %h exp 0", s_valid); end
        checks++; if ({m0_ready, m1_ready} !== 2'b00) begin errors++; $display("FAIL rst_ready got %b exp 00", {m0_ready, m1_ready}); end
        checks++; if ({m0_err, m1_err} !== 2'b00) begin errors++; $display("FAIL rst_err got %b exp 00", {m0_err, m1_err}); end
        checks++; if (s_addr !== 32'h0) begin errors++; $display("FAIL rst_saddr got %h exp 0", s_addr); end
        @(negedge clk); rst = 0;
    endtask

    task automatic test_read();
        @(negedge clk); m0_valid = 1; m0_we = 0; m0_addr = 32'h1000_0010; #1;
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL rd_idle_svalid got %h exp 0", s_valid); end
        @(negedge clk); #1;
        checks++; if (s_valid !== 1'b1) begin errors++; $display("FAIL rd_svalid got %h exp 1", s_valid); end
        checks++; if (s_addr !== 32'h1000_0010) begin errors++; $display("FAIL rd_saddr got %h exp 10000010", s_addr); end
        checks++; if (s_we !== 1'b0) begin errors++; $display("FAIL rd_swe got %h exp 0", s_we); end
        checks++; if ({busy, grant} !== 2'b10) begin errors++; $display("FAIL rd_busy_grant got %b exp 10", {busy, grant}); end
        checks++; if (m0_ready !== 1'b0) begin errors++; $display("FAIL rd_early1 got %h exp 0", m0_ready); end
        @(negedge clk); #1;
        checks++; if (m0_ready !== 1'b0) begin errors++; $display("FAIL rd_early2 got %h exp 0", m0_ready); end
        @(negedge clk); s_ready = 1; s_rdata = 32'hCAFE_F00D; #1;
        checks++; if (m0_ready !== 1'b1) begin errors++; $display("FAIL rd_ready got %h exp 1", m0_ready); end
        checks++; if (m0_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL rd_rdata got %h exp cafef00d", m0_rdata); end
        checks++; if (m0_err !== 1'b0) begin errors++; $display("FAIL rd_err got %h exp 0", m0_err); end
        checks++; if ({m1_ready, m1_err, m1_rdata} !== 34'h0) begin errors++; $display("FAIL rd_m1_quiet got %h exp 0", {m1_ready, m1_err, m1_rdata}); end
        @(negedge clk); s_ready = 0; s_rdata = 0; m0_valid = 0; #1;
        checks++; if ({busy, s_valid, m0_ready} !== 3'b100) begin errors++; $display("FAIL rd_done got %b exp 100", {busy, s_valid, m0_ready}); end
        @(negedge clk); #1;
        checks++; if ({busy, grant} !== 2'b00) begin errors++; $display("FAIL rd_idle got %b exp 00", {busy, grant}); end
    endtask

    task automatic test_round_robin();
        logic        exp_g [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] exp_a;
        rst = 1; @(negedge clk); rst = 0;
        m0_valid = 1; m0_addr = 32'h0000_0100; m1_valid = 1; m1_addr = 32'h0000_0200;
        for (int i = 0; i < 4; i++) begin
            exp_a = exp_g[i] ? 32'h0000_0200 : 32'h0000_0100;
            @(negedge clk); #1;
            checks++; if (grant !== exp_g[i]) begin errors++; $display("FAIL rr_grant%0d got %h exp %h", i, grant, exp_g[i]); end
            checks++; if (s_addr !== exp_a) begin errors++; $display("FAIL rr_addr%0d got %h exp %h", i, s_addr, exp_a); end
            s_ready = 1; #1;
            checks++; if ({m1_ready, m0_ready} !== (exp_g[i] ? 2'b10 : 2'b01)) begin errors++; $display("FAIL rr_ready%0d got %b", i, {m1_ready, m0_ready}); end
            @(negedge clk); s_ready = 0;
            @(negedge clk);
        end
        m0_valid = 0; m1_valid = 0;
    endtask

    task automatic test_write_hold();
        @(negedge clk); m1_valid = 1; m1_we = 1; m1_addr = 32'h1000_0000;
        m1_wdata = 32'h1234_5678; m1_wstrb = 4'h3;
        @(negedge clk); m1_wdata = 0; m1_wstrb = 4'hF; m1_addr = 32'hDEAD_0000; #1;
        checks++; if (grant !== 1'b1) begin errors++; $display("FAIL wr_grant got %h exp 1", grant); end
        checks++; if (s_wdata !== 32'h1234_5678) begin errors++; $display("FAIL wr_wdata1 got %h exp 12345678", s_wdata); end
        checks++; if (s_wstrb !== 4'h3) begin errors++; $display("FAIL wr_wstrb1 got %h exp 3", s_wstrb); end
        checks++; if ({s_we, s_addr} !== {1'b1, 32'h1000_0000}) begin errors++; $display("FAIL wr_we_addr got %h", {s_we, s_addr}); end
        @(negedge clk); #1;
        checks++; if ({s_wstrb, s_wdata} !== {4'h3, 32'h1234_5678}) begin errors++; $display("FAIL wr_hold2 got %h", {s_wstrb, s_wdata}); end
        s_ready = 1; s_rdata = 32'hFFFF_FFFF; #1;
        checks++; if (m1_ready !== 1'b1) begin errors++; $display("FAIL wr_ready got %h exp 1", m1_ready); end
        checks++; if (m1_rdata !== 32'h0) begin errors++; $display("FAIL wr_rdata got %h exp 0", m1_rdata); end
        checks++; if ({m0_ready, m0_rdata} !== 33'h0) begin errors++; $display("FAIL wr_m0_quiet got %h exp 0", {m0_ready, m0_rdata}); end
        @(negedge clk); s_ready = 0; s_rdata = 0; idle_inputs();
        @(negedge clk);
    endtask

    task automatic test_drop_valid();
        @(negedge clk); m0_valid = 1; m0_we = 1; m0_addr = 32'h20; m0_wdata = 32'hA5A5_A5A5; m0_wstrb = 4'h0;
        @(negedge clk); m0_valid = 0; #1;
        checks++; if ({s_valid, s_wstrb} !== 5'b1_0000) begin errors++; $display("FAIL dv_strb0 got %b exp 10000", {s_valid, s_wstrb}); end
        checks++; if (s_wdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL dv_wdata got %h exp a5a5a5a5", s_wdata); end
        @(negedge clk); s_ready = 1; #1;
        checks++; if ({m0_ready, m0_err} !== 2'b10) begin errors++; $display("FAIL dv_ready got %b exp 10", {m0_ready, m0_err}); end
        @(negedge clk); s_ready = 0;
        @(negedge clk); idle_inputs();
    endtask

    task automatic test_fast();
        @(negedge clk); m0_valid = 1; m0_we = 0; m0_addr = 32'h40;
        @(negedge clk); s_ready = 1; s_rdata = 32'h1111_2222; #1;
        checks++; if ({busy, m0_ready} !== 2'b11) begin errors++; $display("FAIL fast_ready got %b exp 11", {busy, m0_ready}); end
        checks++; if (m0_rdata !== 32'h1111_2222) begin errors++; $display("FAIL fast_rdata got %h exp 11112222", m0_rdata); end
        @(negedge clk); s_ready = 0; s_rdata = 0; m0_valid = 0; #1;
        checks++; if ({busy, m0_ready} !== 2'b10) begin errors++; $display("FAIL fast_done got %b exp 10", {busy, m0_ready}); end
        @(negedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fast_idle got %h exp 0", busy); end
    endtask

    task automatic test_reset_midbusy();
        // m1 in flight, then reset
        @(negedge clk); m1_valid = 1; m1_addr = 32'h300;
        @(negedge clk); #1;
        checks++; if ({grant, s_valid} !== 2'b11) begin errors++; $display("FAIL rb_pre got %b exp 11", {grant, s_valid}); end
        s_ready = 1; rst = 1; #1;
        checks++; if ({s_valid, busy, m1_ready} !== 3'b000) begin errors++; $display("FAIL rb_async got %b exp 000", {s_valid, busy, m1_ready}); end
        @(negedge clk); rst = 0; s_ready = 0; m0_valid = 1; m0_addr = 32'h400;
        @(negedge clk); #1;
        checks++; if (grant !== 1'b0) begin errors++; $display("FAIL rb_grant_a got %h exp 0", grant); end
        s_ready = 1;
        @(negedge clk); s_ready = 0; m0_valid = 0; m1_valid = 0;
        @(negedge clk);
        // m0 in flight, then reset: pointer would otherwise favour m1
        m0_valid = 1;
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0; m1_valid = 1;
        @(negedge clk); #1;
        checks++; if ({busy, grant} !== 2'b10) begin errors++; $display("FAIL rb_grant_b got %b exp 10", {busy, grant}); end
        s_ready = 1;
        @(negedge clk); idle_inputs();
        @(negedge clk);
    endtask

`ifdef DMEM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        @(negedge clk); m0_valid = 1; m0_we = 0; m0_addr = 32'h80; s_rdata = 32'hBAD0_BAD0;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk); #1;
            checks++; if ({s_valid, m0_ready} !== 2'b10) begin errors++; $display("FAIL to_wait%0d got %b exp 10", i, {s_valid, m0_ready}); end
        end
        @(negedge clk); #1;
        checks++; if ({m0_ready, m0_err, s_valid} !== 3'b110) begin errors++; $display("FAIL to_fire got %b exp 110", {m0_ready, m0_err, s_valid}); end
        checks++; if (m0_rdata !== 32'h0) begin errors++; $display("FAIL to_rdata got %h exp 0", m0_rdata); end
        @(negedge clk); m0_valid = 0; #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL to_done got %h exp 1", busy); end
        @(negedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_idle got %h exp 0", busy); end
        // s_ready on the limit cycle completes normally
        m0_valid = 1;
        for (int i = 1; i <= 3; i++) @(negedge clk);
        @(negedge clk); s_ready = 1; #1;
        checks++; if ({m0_ready, m0_err} !== 2'b10) begin errors++; $display("FAIL to_race got %b exp 10", {m0_ready, m0_err}); end
        checks++; if (m0_rdata !== 32'hBAD0_BAD0) begin errors++; $display("FAIL to_race_rdata got %h exp bad0bad0", m0_rdata); end
        @(negedge clk); idle_inputs();
        @(negedge clk);
    endtask
`endif

    initial begin
        idle_inputs();
        rst = 1;
        test_reset();
        test_read();
        test_round_robin();
        test_write_hold();
        test_drop_valid();
        test_fast();
        test_reset_midbusy();
`ifdef DMEM_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
